adrv9001_en_seq: RTL and testbench

Parametrised enable-pin sequencer for the ADRV9001 RX/TX enable pins (rx1_en, tx1_en, rx2_en, tx2_en, and more on multi-transceiver builds). It sits between the control logic (DMA/TDD triggers, software registers) and the device pins. It turns a level request per channel into a timed pin/datapath sequence:

- The pin rises a programmable number of cycles before the FPGA datapath is enabled.
- The pin falls a programmable number of cycles after the datapath is disabled.
- An optional TDD interlock keeps each RX/TX pair mutually exclusive.

---
 rtl/adrv9001_en_seq.sv | 134 +++++++++++++
 tb/tb_adrv9001_en_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adrv9001_en_seq.sv
// ADRV9001 enable-pin sequencer: per-channel IDLE/SETUP/ACTIVE/HOLD FSM
// that raises the device pin ahead of the datapath enable and drops it
// after, with an optional RX/TX interlock per pair.
module adrv9001_en_seq #(
    parameter int NUM_PAIRS = 2,
    parameter int CNT_W     = 16,
    parameter bit TDD_MODE  = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2*NUM_PAIRS-1:0]         req,
    input  logic [2*NUM_PAIRS*CNT_W-1:0]   cfg_setup_dly,
    input  logic [2*NUM_PAIRS*CNT_W-1:0]   cfg_hold_dly,
    input  logic [2*NUM_PAIRS-1:0]         conflict_clr,
    output logic [2*NUM_PAIRS-1:0]         en_pin,
    output logic [2*NUM_PAIRS-1:0]         dp_en,
    output logic [2*NUM_PAIRS-1:0]         busy,
    output logic [2*NUM_PAIRS-1:0]         conflict
);

    localparam int NUM_CH = 2 * NUM_PAIRS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACTIVE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t           state    [NUM_CH];
    state_t           state_nx [NUM_CH];
    logic [CNT_W-1:0] cnt      [NUM_CH];
    logic [CNT_W-1:0] cnt_nx   [NUM_CH];
    logic [NUM_CH-1:0] conflict_q;
    logic [NUM_CH-1:0] conflict_nx;
    logic [NUM_CH-1:0] blocked;

    // Interlock: a channel may not leave IDLE while its partner is busy;
    // on a simultaneous request from both idle partners the RX side wins.
    always_comb begin
        blocked = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (TDD_MODE) begin
                if (state[k ^ 32'd1] != IDLE) begin
                    blocked[k] = 1'b1;
                end else if ((k % 2) == 1 && req[k ^ 32'd1]) begin
                    blocked[k] = 1'b1;
                end
            end
        end
    end

    // Next-state, counter and sticky conflict logic for every channel.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            state_nx[k] = state[k];
            cnt_nx[k]   = cnt[k];
        end
        conflict_nx = conflict_q & ~conflict_clr;

        for (int unsigned k = 0; k < NUM_CH; k++) begin
            // set has priority over the write-1-to-clear
            if (state[k] == IDLE && req[k] && blocked[k]) begin
                conflict_nx[k] = 1'b1;
            end

            case (state[k])
                IDLE: begin
                    if (req[k] && !blocked[k]) begin
                        state_nx[k] = SETUP;
                        cnt_nx[k]   = cfg_setup_dly[k*CNT_W +: CNT_W];
                    end
                end
                SETUP: begin
                    if (!req[k]) begin
                        state_nx[k] = IDLE;
                    end else if (cnt[k] == '0) begin
                        state_nx[k] = ACTIVE;
                    end else begin
                        cnt_nx[k] = cnt[k] - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!req[k]) begin
                        state_nx[k] = HOLD;
                        cnt_nx[k]   = cfg_hold_dly[k*CNT_W +: CNT_W];
                    end
                end
                HOLD: begin
                    if (cnt[k] == '0) begin
                        state_nx[k] = IDLE;
                    end else begin
                        cnt_nx[k] = cnt[k] - 1'b1;
                    end
                end
                default: begin
                    state_nx[k] = IDLE;
                end
            endcase
        end
    end

    // State, counter and conflict registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                state[k] <= IDLE;
                cnt[k]   <= '0;
            end
            conflict_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                state[k] <= state_nx[k];
                cnt[k]   <= cnt_nx[k];
            end
            conflict_q <= conflict_nx;
        end
    end

    // Outputs are a pure decode of the registered state.
    always_comb begin
        en_pin = '0;
        dp_en  = '0;
        busy   = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            en_pin[k] = (state[k] != IDLE);
            dp_en[k]  = (state[k] == ACTIVE);
            busy[k]   = (state[k] != IDLE);
        end
    end

    assign conflict = conflict_q;

endmodule

// File: tb/tb_adrv9001_en_seq.sv
// Bench for adrv9001_en_seq: one interlocked and one independent instance
// driven from the same inputs and compared every cycle with a timestamp
// model, plus directed latency / interlock / reset / wrap scenarios.
module tb_adrv9001_en_seq;

    localparam int NP = 2;
    localparam int NC = 2 * NP;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] req;
    logic [NC-1:0] clr;
    logic [NC*CW-1:0] cfg_s;
    logic [NC*CW-1:0] cfg_h;

    logic [NC-1:0] en_a, dp_a, busy_a, conf_a;
    logic [NC-1:0] en_b, dp_b, busy_b, conf_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // model: per instance (0 = interlocked, 1 = independent), per channel
    bit on   [2][NC];
    bit rel  [2][NC];
    int t0   [2][NC];
    int tr   [2][NC];
    int mn   [2][NC];
    int mm   [2][NC];
    bit mconf[2][NC];

    adrv9001_en_seq #(.NUM_PAIRS(NP), .CNT_W(CW), .TDD_MODE(1'b1)) u_tdd (
        .clk(clk), .rst(rst), .req(req), .cfg_setup_dly(cfg_s),
        .cfg_hold_dly(cfg_h), .conflict_clr(clr), .en_pin(en_a),
        .dp_en(dp_a), .busy(busy_a), .conflict(conf_a)
    );

    adrv9001_en_seq #(.NUM_PAIRS(NP), .CNT_W(CW), .TDD_MODE(1'b0)) u_ind (
        .clk(clk), .rst(rst), .req(req), .cfg_setup_dly(cfg_s),
        .cfg_hold_dly(cfg_h), .conflict_clr(clr), .en_pin(en_b),
        .dp_en(dp_b), .busy(busy_b), .conflict(conf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Phase of a channel just after edge x: 0 idle, 1 pin-only lead-in,
    // 2 datapath on, 3 pin-only tail. Derived from entry/release timestamps.
    function automatic int phase(int i, int k, int x);
        if (!on[i][k]) return 0;
        if (!rel[i][k]) return (x - t0[i][k] <= mn[i][k]) ? 1 : 2;
        return (x - tr[i][k] <= mm[i][k]) ? 3 : 0;
    endfunction

    task automatic model_edge();
        int e;
        int cur [2][NC];
        bit blk;
        e = cyc;
        if (rst) begin
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < NC; k++) begin
                    on[i][k] = 0; rel[i][k] = 0; mconf[i][k] = 0;
                end
            return;
        end
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NC; k++)
                cur[i][k] = phase(i, k, e - 1);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NC; k++) begin
                int p;
                p = k ^ 1;
                blk = (i == 0) && (cur[i][p] != 0 || ((k % 2) == 1 && req[p]));
                if (cur[i][k] == 0 && req[k] && blk) mconf[i][k] = 1;
                else if (clr[k]) mconf[i][k] = 0;
                case (cur[i][k])
                    0: if (req[k] && !blk) begin
                        on[i][k] = 1; rel[i][k] = 0; t0[i][k] = e;
                        mn[i][k] = int'(cfg_s[k*CW +: CW]);
                    end
                    1: if (!req[k]) on[i][k] = 0;
                    2: if (!req[k]) begin
                        rel[i][k] = 1; tr[i][k] = e;
                        mm[i][k] = int'(cfg_h[k*CW +: CW]);
                    end
                    default: ;
                endcase
                if (phase(i, k, e) == 0) begin
                    on[i][k] = 0; rel[i][k] = 0;
                end
            end
    endtask

    task automatic compare_all();
        logic [NC-1:0] xe, xd, xc;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NC; k++) begin
                xe[k] = (phase(i, k, cyc) != 0);
                xd[k] = (phase(i, k, cyc) == 2);
                xc[k] = mconf[i][k];
            end
            chk(i == 0 ? "tdd_en_pin" : "ind_en_pin", 32'(i == 0 ? en_a : en_b), 32'(xe));
            chk(i == 0 ? "tdd_dp_en" : "ind_dp_en", 32'(i == 0 ? dp_a : dp_b), 32'(xd));
            chk(i == 0 ? "tdd_busy" : "ind_busy", 32'(i == 0 ? busy_a : busy_b), 32'(xe));
            chk(i == 0 ? "tdd_conflict" : "ind_conflict", 32'(i == 0 ? conf_a : conf_b), 32'(xc));
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_cfg(input int k, input int n, input int m);
        cfg_s[k*CW +: CW] = CW'(n);
        cfg_h[k*CW +: CW] = CW'(m);
    endtask

    initial begin
        rst = 1'b1; req = '0; clr = '0; cfg_s = '0; cfg_h = '0;
        steps(2);
        chk("reset_outputs", {en_a, dp_a, busy_a, conf_a}, 32'h0);
        rst = 1'b0;
        steps(2);

        // basic sequence N=3, M=2 on ch0
        set_cfg(0, 3, 2);
        req[0] = 1'b1;
        step();
        chk("basic_en_rise", 32'(en_a[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("basic_dp_still_low", 32'(dp_a[0]), 32'd0);
        end
        step();
        chk("basic_dp_rise", 32'(dp_a[0]), 32'd1);
        steps(10);
        req[0] = 1'b0;
        step();
        chk("basic_dp_fall", 32'(dp_a[0]), 32'd0);
        chk("basic_en_in_hold", 32'(en_a[0]), 32'd1);
        steps(2);
        chk("basic_en_hold_end", 32'(en_a[0]), 32'd1);
        step();
        chk("basic_en_fall", 32'(en_a[0]), 32'd0);
        chk("basic_others_quiet", 32'({en_a[3:1], dp_a[3:1], conf_a}), 32'd0);
        steps(3);

        // zero delays, 5-cycle request
        set_cfg(0, 0, 0);
        req[0] = 1'b1;
        step();
        chk("zero_en_rise", 32'(en_a[0]), 32'd1);
        chk("zero_dp_low", 32'(dp_a[0]), 32'd0);
        step();
        chk("zero_dp_rise", 32'(dp_a[0]), 32'd1);
        steps(3);
        req[0] = 1'b0;
        step();
        chk("zero_dp_fall", 32'(dp_a[0]), 32'd0);
        chk("zero_en_tail", 32'(en_a[0]), 32'd1);
        step();
        chk("zero_en_fall", 32'(en_a[0]), 32'd0);
        steps(3);

        // setup abort
        set_cfg(0, 10, 0);
        req[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_en_high", 32'(en_a[0]), 32'd1);
            chk("abort_dp_low", 32'(dp_a[0]), 32'd0);
        end
        req[0] = 1'b0;
        step();
        chk("abort_idle", 32'({en_a[0], busy_a[0], dp_a[0]}), 32'd0);
        steps(3);

        // interlock: TX requests while RX is active
        set_cfg(0, 1, 1);
        set_cfg(1, 0, 0);
        req[0] = 1'b1;
        steps(4);
        req[1] = 1'b1;
        step();
        chk("lock_tx_blocked", 32'(busy_a[1]), 32'd0);
        chk("lock_conflict_set", 32'(conf_a[1]), 32'd1);
        chk("lock_ind_runs", 32'(busy_b[1]), 32'd1);
        req[0] = 1'b0;
        steps(2);
        chk("lock_rx_in_hold", 32'(en_a[0]), 32'd1);
        step();
        chk("lock_rx_fall", 32'(en_a[0]), 32'd0);
        chk("lock_tx_still_low", 32'(en_a[1]), 32'd0);
        step();
        chk("lock_tx_rise", 32'(en_a[1]), 32'd1);
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        chk("lock_conflict_clr", 32'(conf_a[1]), 32'd0);
        req[1] = 1'b0;
        steps(4);

        // simultaneous request
        req[1:0] = 2'b11;
        step();
        chk("simul_tdd_busy", 32'(busy_a[1:0]), 32'd1);
        chk("simul_tdd_conflict", 32'(conf_a[1]), 32'd1);
        chk("simul_ind_busy", 32'(busy_b[1:0]), 32'd3);
        chk("simul_ind_conflict", 32'(conf_b), 32'd0);
        req[1:0] = 2'b00;
        clr = '1;
        step();
        clr = '0;
        steps(4);

        // hold length latched at load despite cfg change
        set_cfg(0, 0, 3);
        req[0] = 1'b1;
        steps(2);
        req[0] = 1'b0;
        step();
        set_cfg(0, 0, 20);
        steps(3);
        chk("cfg_hold_latched_on", 32'(en_a[0]), 32'd1);
        step();
        chk("cfg_hold_latched_off", 32'(en_a[0]), 32'd0);
        steps(2);

        // reset during hold
        set_cfg(0, 0, 5);
        req[0] = 1'b1;
        steps(3);
        req[0] = 1'b0;
        steps(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_hold_outputs", {en_a, dp_a, busy_a, conf_a}, 32'h0);
        steps(2);

        // maximum setup delay: no counter wrap
        set_cfg(2, 255, 0);
        req[2] = 1'b1;
        step();
        for (int i = 0; i < 255; i++) step();
        chk("wrap_dp_low", 32'(dp_a[2]), 32'd0);
        step();
        chk("wrap_dp_rise", 32'(dp_a[2]), 32'd1);
        req[2] = 1'b0;
        steps(3);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NC; k++) begin
                if ($urandom_range(7) == 0) req[k] = ~req[k];
                if ($urandom_range(15) == 0) set_cfg(k, $urandom_range(6), $urandom_range(6));
                clr[k] = ($urandom_range(15) == 0);
            end
            rst = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;
        clr = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
